mem_arbiter: RTL and testbench

- Shares the single pipelined main-memory port between the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores.
- Sits between both cache controllers and the memory model.
- Grants the port to one requester at a time and holds it for a whole block fill or one store.
- Routes memory address, enable, write and data-valid signals to and from the granted requester only.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/beat_counter.sv | 64 ++++++
 rtl/cla_adder_4bit.sv | 28 ++
 rtl/dff.sv | 20 ++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 6 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory port arbiter: state encodings,
// fill-owner constants and the round-robin fill selection helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_I_FILL = 2'b01,
    ARB_D_FILL = 2'b10,
    ARB_D_WR   = 2'b11
  } arb_state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // When both caches miss, the side that did not own the previous fill wins.
  function automatic arb_state_t pick_fill(input logic i_req,
                                           input logic d_req,
                                           input logic last_owner);
    if (i_req && d_req)
      return (last_owner == OWNER_I) ? ARB_D_FILL : ARB_I_FILL;
    else if (i_req)
      return ARB_I_FILL;
    else
      return ARB_D_FILL;
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Saturating fill-beat counter with clear and a sticky overflow flag that is
// raised by any increment attempted while the count already equals BLOCK_WORDS.
module beat_counter #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic err
);

  localparam int CNT_W   = $clog2(BLOCK_WORDS) + 1;
  localparam int N_SLICE = (CNT_W + 3) / 4;
  localparam int PAD_W   = 4 * N_SLICE;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [PAD_W-1:0] cnt_pad;
  logic [PAD_W-1:0] sum_pad;
  logic [N_SLICE:0] carry;
  logic             sat;
  logic             err_q;
  logic             err_d;
  logic             unused_bits;

  assign cnt_pad  = PAD_W'(cnt_q);
  assign carry[0] = 1'b1;

  // Increment-by-one built from chained lookahead slices (b=0, cin=1).
  for (genvar s = 0; s < N_SLICE; s++) begin : g_slice
    cla_adder_4bit u_add (
      .a    (cnt_pad[4*s +: 4]),
      .b    (4'b0000),
      .cin  (carry[s]),
      .sum  (sum_pad[4*s +: 4]),
      .cout (carry[s+1])
    );
  end

  assign unused_bits = ^{carry[N_SLICE], sum_pad};

  assign sat = (cnt_q == CNT_W'(BLOCK_WORDS));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !sat)
      cnt_d = sum_pad[CNT_W-1:0];
  end

  assign err_d = err_q | (inc & sat);
  assign err   = err_q;

  dff #(.W(CNT_W), .RST_VAL('0)) u_cnt (
    .clk (clk), .rst (rst), .wen (1'b1), .d (cnt_d), .q (cnt_q)
  );

  dff #(.W(1), .RST_VAL(1'b0)) u_err (
    .clk (clk), .rst (rst), .wen (1'b1), .d (err_d), .q (err_q)
  );

endmodule

// File: rtl/cla_adder_4bit.sv
// 4-bit carry-lookahead adder slice with carry in and carry out.
module cla_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
                (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
                (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/dff.sv
// Generic register with synchronous active-high reset and write enable.
module dff #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wen,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= RST_VAL;
    else if (wen)
      q <= d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the pipelined main-memory port between the I-cache fill,
// D-cache fill and D-cache write-through store paths.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fill_req,
  input  logic [ADDR_W-1:0] i_fill_addr,
  input  logic              i_fill_done,
  output logic              i_grant,
  output logic              i_data_valid,
  input  logic              d_fill_req,
  input  logic [ADDR_W-1:0] d_fill_addr,
  input  logic              d_fill_done,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  output logic              d_grant,
  output logic              d_data_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_enable,
  output logic              mem_wr,
  input  logic              mem_data_valid,
  output logic              beat_err
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic [1:0] state_q;
  logic       last_owner;
  logic       owner_nxt;
  logic       beat_inc;
  logic       beat_clr;

  dff #(.W(2), .RST_VAL(2'(ARB_IDLE))) u_state (
    .clk (clk), .rst (rst), .wen (1'b1), .d (2'(state_nxt)), .q (state_q)
  );

  dff #(.W(1), .RST_VAL(OWNER_I)) u_owner (
    .clk (clk), .rst (rst), .wen (1'b1), .d (owner_nxt), .q (last_owner)
  );

  assign state = arb_state_t'(state_q);

  // Outputs decode purely from state; stores always beat fills out of IDLE.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = last_owner;
    i_grant      = 1'b0;
    i_data_valid = 1'b0;
    d_grant      = 1'b0;
    d_data_valid = 1'b0;
    d_wr_ack     = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    beat_inc     = 1'b0;
    beat_clr     = 1'b0;

    case (state)
      ARB_IDLE: begin
        if (d_wr_req)
          state_nxt = ARB_D_WR;
        else if (i_fill_req || d_fill_req)
          state_nxt = pick_fill(i_fill_req, d_fill_req, last_owner);
      end

      ARB_I_FILL: begin
        i_grant      = 1'b1;
        mem_enable   = 1'b1;
        mem_addr     = i_fill_addr;
        i_data_valid = mem_data_valid;
        beat_inc     = mem_data_valid;
        if (i_fill_done) begin
          state_nxt = ARB_IDLE;
          owner_nxt = OWNER_I;
          beat_clr  = 1'b1;
        end
      end

      ARB_D_FILL: begin
        d_grant      = 1'b1;
        mem_enable   = 1'b1;
        mem_addr     = d_fill_addr;
        d_data_valid = mem_data_valid;
        beat_inc     = mem_data_valid;
        if (d_fill_done) begin
          state_nxt = ARB_IDLE;
          owner_nxt = OWNER_D;
          beat_clr  = 1'b1;
        end
      end

      ARB_D_WR: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = d_wr_addr;
        mem_wdata  = d_wr_data;
        d_wr_ack   = 1'b1;
        state_nxt  = ARB_IDLE;
      end

      default: state_nxt = ARB_IDLE;
    endcase
  end

  beat_counter #(.BLOCK_WORDS(BLOCK_WORDS)) u_beats (
    .clk (clk),
    .rst (rst),
    .clr (beat_clr),
    .inc (beat_inc),
    .err (beat_err)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected port
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_arbiter;

  typedef enum logic [2:0] {EV_GRANT_I, EV_GRANT_D, EV_BEAT_I, EV_BEAT_D, EV_WR} ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_fill_req, i_fill_done, d_fill_req, d_fill_done, d_wr_req;
  logic [15:0] i_fill_addr, d_fill_addr, d_wr_addr, d_wr_data;
  logic        mem_data_valid;
  logic        i_grant, i_data_valid, d_wr_ack, d_grant, d_data_valid;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_enable, mem_wr, beat_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  ev_t  exp_q[$];
  logic mon_en  = 1'b0;
  logic prev_ig = 1'b0;
  logic prev_dg = 1'b0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_fill_req     (i_fill_req),
    .i_fill_addr    (i_fill_addr),
    .i_fill_done    (i_fill_done),
    .i_grant        (i_grant),
    .i_data_valid   (i_data_valid),
    .d_fill_req     (d_fill_req),
    .d_fill_addr    (d_fill_addr),
    .d_fill_done    (d_fill_done),
    .d_wr_req       (d_wr_req),
    .d_wr_addr      (d_wr_addr),
    .d_wr_data      (d_wr_data),
    .d_wr_ack       (d_wr_ack),
    .d_grant        (d_grant),
    .d_data_valid   (d_data_valid),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_data_valid (mem_data_valid),
    .beat_err       (beat_err)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL unexpected_event: got %s addr 0x%0h data 0x%0h, expected none",
               k.name(), a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.addr !== a || e.data !== d) begin
        n_fail++;
        $display("[TB] FAIL event: got %s addr 0x%0h data 0x%0h, expected %s addr 0x%0h data 0x%0h",
                 k.name(), a, d, e.kind.name(), e.addr, e.data);
      end
    end
  endtask

  // Monitor: events in the order grant, beat, store within one cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (i_grant && !prev_ig) observe(EV_GRANT_I, mem_addr, 16'h0);
      if (d_grant && !prev_dg) observe(EV_GRANT_D, mem_addr, 16'h0);
      if (i_data_valid)        observe(EV_BEAT_I, mem_addr, 16'h0);
      if (d_data_valid)        observe(EV_BEAT_D, mem_addr, 16'h0);
      if (d_wr_ack)            observe(EV_WR, mem_addr, mem_wdata);
      checkOutput("port_invariants",
                  {27'd0, i_grant & d_grant, mem_wr ^ d_wr_ack,
                   d_data_valid & ~d_grant, i_data_valid & ~i_grant,
                   mem_enable ^ (i_grant | d_grant | d_wr_ack)}, 32'd0);
    end
    prev_ig = i_grant;
    prev_dg = d_grant;
  end

  initial begin
    rst = 1'b1;
    i_fill_req = 0; i_fill_done = 0; d_fill_req = 0; d_fill_done = 0; d_wr_req = 0;
    i_fill_addr = '0; d_fill_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    mem_data_valid = 0;
    applyStimulus(2);
    mon_en = 1'b1;
    checkOutput("rst_i_grant", i_grant, 0);
    checkOutput("rst_d_grant", d_grant, 0);
    checkOutput("rst_mem_enable", mem_enable, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_beat_err", beat_err, 0);
    rst = 1'b0;

    // I fill interrupted by a two-cycle reset
    i_fill_req = 1; i_fill_addr = 16'h7000;
    expect_ev(EV_GRANT_I, 16'h7000, 16'h0);
    applyStimulus(1);
    mem_data_valid = 1;
    for (int k = 0; k < 2; k++) begin
      expect_ev(EV_BEAT_I, 16'h7000, 16'h0);
      applyStimulus(1);
    end
    mem_data_valid = 0;
    rst = 1; i_fill_req = 0;
    applyStimulus(2);
    rst = 0;
    checkOutput("midrst_i_grant", i_grant, 0);
    checkOutput("midrst_d_grant", d_grant, 0);
    checkOutput("midrst_mem_enable", mem_enable, 0);
    checkOutput("midrst_beat_err", beat_err, 0);

    // Contention: last owner is I after reset, so D wins first
    i_fill_req = 1; i_fill_addr = 16'h1230;
    d_fill_req = 1; d_fill_addr = 16'h2200;
    expect_ev(EV_GRANT_D, 16'h2200, 16'h0);
    applyStimulus(1);
    for (int k = 0; k < 8; k++) begin
      d_fill_addr = 16'h2200 + 16'(2 * k);
      mem_data_valid = 1;
      expect_ev(EV_BEAT_D, d_fill_addr, 16'h0);
      applyStimulus(1);
    end
    mem_data_valid = 0; d_fill_done = 1; d_fill_req = 0;
    applyStimulus(1);
    d_fill_done = 0;
    checkOutput("bubble_i_grant", i_grant, 0);
    checkOutput("bubble_d_grant", d_grant, 0);
    checkOutput("bubble_beat_err", beat_err, 0);
    expect_ev(EV_GRANT_I, 16'h1230, 16'h0);
    applyStimulus(1);

    // I fill with a store and a D fill arriving mid-fill, plus a stray D done
    d_wr_req = 1; d_wr_addr = 16'h4000; d_wr_data = 16'hBEEF;
    d_fill_req = 1; d_fill_addr = 16'h5000;
    for (int k = 0; k < 8; k++) begin
      i_fill_addr = 16'h1230 + 16'(2 * k);
      mem_data_valid = 1;
      d_fill_done = (k == 3);
      expect_ev(EV_BEAT_I, i_fill_addr, 16'h0);
      applyStimulus(1);
    end
    d_fill_done = 0; mem_data_valid = 0; i_fill_done = 1; i_fill_req = 0;
    applyStimulus(1);
    i_fill_done = 0;
    checkOutput("after_ifill_i_grant", i_grant, 0);
    checkOutput("after_ifill_mem_wr", mem_wr, 0);
    expect_ev(EV_WR, 16'h4000, 16'hBEEF);
    applyStimulus(1);
    d_wr_req = 0;
    checkOutput("store_mem_wr", mem_wr, 1);
    expect_ev(EV_GRANT_D, 16'h5000, 16'h0);
    applyStimulus(1);
    checkOutput("post_store_ack", d_wr_ack, 0);
    checkOutput("post_store_d_grant", d_grant, 0);
    applyStimulus(1);

    // D fill with nine beats: overflow flag on the ninth
    for (int k = 0; k < 9; k++) begin
      d_fill_addr = 16'h5000 + 16'(2 * k);
      mem_data_valid = 1;
      expect_ev(EV_BEAT_D, d_fill_addr, 16'h0);
      applyStimulus(1);
      if (k == 7) checkOutput("beat8_err", beat_err, 0);
      if (k == 8) checkOutput("beat9_err", beat_err, 1);
    end
    mem_data_valid = 0; d_fill_done = 1; d_fill_req = 0;
    applyStimulus(1);
    d_fill_done = 0;
    checkOutput("after_dfill_d_grant", d_grant, 0);
    checkOutput("sticky_beat_err", beat_err, 1);

    // Stray memory valid and D done while idle
    mem_data_valid = 1; d_fill_done = 1;
    applyStimulus(1);
    mem_data_valid = 0; d_fill_done = 0;
    checkOutput("spurious_i_grant", i_grant, 0);
    checkOutput("spurious_d_grant", d_grant, 0);
    checkOutput("spurious_mem_enable", mem_enable, 0);
    checkOutput("spurious_beat_err", beat_err, 1);

    rst = 1;
    applyStimulus(1);
    rst = 0;
    checkOutput("rst_clears_beat_err", beat_err, 0);

    applyStimulus(2);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
